// File: rtl/mbist_fault_campaign_seq.sv
`default_nettype none
// ============================================================================
// Module   : mbist_fault_campaign_seq
// Brief    : Walks a programmable fault list, running one MBIST pass per entry
//            and logging detections. Define MBIST_SEQ_GOLDEN_EN to add a
//            fault-free golden pre-pass ahead of the list.
// Revision : 1.0
// ============================================================================
module mbist_fault_campaign_seq #(
    parameter int  ADDR_WIDTH     = 8,
    parameter int  NUM_ENTRIES    = 8,
    parameter int  RST_CYCLES     = 4,
    parameter int  ARM_CYCLES     = 4,
    parameter int  TIMEOUT_CYCLES = 200000,
    localparam int IDX_W          = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_we,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic [2:0]             cfg_kind,
    input  logic [ADDR_WIDTH-1:0]  cfg_addr,
    input  logic [ADDR_WIDTH-1:0]  cfg_target,
    input  logic [IDX_W:0]         num_entries,
    input  logic                   go,
    output logic                   busy,
    output logic                   done,
    output logic                   ctrl_rst,
    output logic                   mbist_start,
    input  logic                   test_done,
    input  logic                   fail_flag,
    input  logic [ADDR_WIDTH-1:0]  fail_addr,
    output logic                   fault_enable,
    output logic [ADDR_WIDTH-1:0]  fault_addr,
    output logic [2:0]             fault_type,
    output logic [ADDR_WIDTH-1:0]  fault_target,
    output logic [IDX_W:0]         detect_cnt,
    output logic [IDX_W:0]         miss_cnt,
    output logic [IDX_W:0]         timeout_cnt,
    output logic [NUM_ENTRIES-1:0] miss_mask,
    output logic [ADDR_WIDTH-1:0]  last_fail_addr,
    output logic                   golden_fail
);

    localparam int c_CNT_MAX_A = (RST_CYCLES > ARM_CYCLES) ? RST_CYCLES : ARM_CYCLES;
    localparam int c_CNT_MAX   = (TIMEOUT_CYCLES > c_CNT_MAX_A) ? TIMEOUT_CYCLES : c_CNT_MAX_A;
    localparam int c_CNT_W     = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_RST_LAST = c_CNT_W'(RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ARM_LAST = c_CNT_W'(ARM_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT  = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_W:0]     c_NUM      = (IDX_W + 1)'(NUM_ENTRIES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RST   = 3'd2;
    localparam logic [2:0] S_ARM   = 3'd3;
    localparam logic [2:0] S_START = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;
    localparam logic [2:0] S_LOG   = 3'd6;
    localparam logic [2:0] S_FIN   = 3'd7;

    // Fault list storage; deliberately not reset so a campaign can be rerun
    logic [2:0]            r_kind   [NUM_ENTRIES];
    logic [ADDR_WIDTH-1:0] r_addr   [NUM_ENTRIES];
    logic [ADDR_WIDTH-1:0] r_target [NUM_ENTRIES];

    logic [2:0]             r_state;
    logic [2:0]             w_next;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_inc;
    logic [IDX_W:0]         r_idx;
    logic [IDX_W:0]         r_num;
    logic                   r_smp_fail;
    logic                   r_smp_to;
    logic [ADDR_WIDTH-1:0]  r_smp_addr;

    logic                   r_busy;
    logic                   r_done;
    logic                   r_ctrl_rst;
    logic                   r_mbist_start;
    logic                   r_fault_enable;
    logic [ADDR_WIDTH-1:0]  r_fault_addr;
    logic [2:0]             r_fault_type;
    logic [ADDR_WIDTH-1:0]  r_fault_target;
    logic [IDX_W:0]         r_detect_cnt;
    logic [IDX_W:0]         r_miss_cnt;
    logic [IDX_W:0]         r_timeout_cnt;
    logic [NUM_ENTRIES-1:0] r_miss_mask;
    logic [ADDR_WIDTH-1:0]  r_last_fail_addr;
`ifdef MBIST_SEQ_GOLDEN_EN
    logic                   r_golden;
    logic                   r_golden_fail;
`endif

    logic                   w_go_ok;
    logic                   w_cfg_ok;
    logic                   w_cfg_in_range;
    logic [IDX_W:0]         w_num_clamp;
    logic                   w_idx_end;
    logic [2:0]             w_cur_kind;
    logic                   w_wait_to;

    assign w_go_ok     = go && (r_state == S_IDLE) && !r_busy;
    assign w_cfg_ok    = cfg_we && (r_state == S_IDLE) && !r_busy && w_cfg_in_range;
    assign w_num_clamp = (num_entries > c_NUM) ? c_NUM : num_entries;
    assign w_idx_end   = (r_idx >= r_num);
    assign w_cur_kind  = r_kind[r_idx[IDX_W-1:0]];
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_wait_to   = (w_cnt_inc == c_TIMEOUT);

    // Out-of-range indices only exist when NUM_ENTRIES is not a power of two
    generate
        if (NUM_ENTRIES == (1 << IDX_W)) begin : g_idx_full
            assign w_cfg_in_range = 1'b1;
        end else begin : g_idx_part
            assign w_cfg_in_range = ({1'b0, cfg_idx} < c_NUM);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_cfg_ok) begin
            r_kind[cfg_idx]   <= cfg_kind;
            r_addr[cfg_idx]   <= cfg_addr;
            r_target[cfg_idx] <= cfg_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go_ok) begin
`ifdef MBIST_SEQ_GOLDEN_EN
                    w_next = S_RST;
`else
                    w_next = (w_num_clamp == '0) ? S_FIN : S_LOAD;
`endif
                end
            end
            S_LOAD: begin
                if (w_idx_end) begin
                    w_next = S_FIN;
                end else if (w_cur_kind != 3'd0) begin
                    w_next = S_RST;
                end
            end
            S_RST:   if (r_cnt == c_RST_LAST) w_next = S_ARM;
            S_ARM:   if (r_cnt == c_ARM_LAST) w_next = S_START;
            S_START: w_next = S_WAIT;
            // test_done takes priority over a coincident timeout
            S_WAIT:  if (test_done || w_wait_to) w_next = S_LOG;
            S_LOG: begin
                w_next = S_LOAD;
`ifdef MBIST_SEQ_GOLDEN_EN
                if (r_golden && (r_smp_fail || r_smp_to)) begin
                    w_next = S_FIN;
                end
`endif
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt            <= '0;
            r_idx            <= '0;
            r_num            <= '0;
            r_smp_fail       <= 1'b0;
            r_smp_to         <= 1'b0;
            r_smp_addr       <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_ctrl_rst       <= 1'b0;
            r_mbist_start    <= 1'b0;
            r_fault_enable   <= 1'b0;
            r_fault_addr     <= '0;
            r_fault_type     <= '0;
            r_fault_target   <= '0;
            r_detect_cnt     <= '0;
            r_miss_cnt       <= '0;
            r_timeout_cnt    <= '0;
            r_miss_mask      <= '0;
            r_last_fail_addr <= '0;
`ifdef MBIST_SEQ_GOLDEN_EN
            r_golden         <= 1'b0;
            r_golden_fail    <= 1'b0;
`endif
        end else begin
            r_done        <= (r_state == S_FIN);
            r_ctrl_rst    <= (w_next == S_RST);
            r_mbist_start <= (w_next == S_START);
            r_cnt         <= ((r_state == S_IDLE) || (w_next != r_state)) ? '0 : w_cnt_inc;

            if (r_done) begin
                r_busy <= 1'b0;
            end

            if (w_go_ok) begin
                r_busy           <= 1'b1;
                r_idx            <= '0;
                r_num            <= w_num_clamp;
                r_detect_cnt     <= '0;
                r_miss_cnt       <= '0;
                r_timeout_cnt    <= '0;
                r_miss_mask      <= '0;
                r_last_fail_addr <= '0;
                r_fault_enable   <= 1'b0;
                r_fault_addr     <= '0;
                r_fault_type     <= '0;
                r_fault_target   <= '0;
`ifdef MBIST_SEQ_GOLDEN_EN
                r_golden         <= 1'b1;
                r_golden_fail    <= 1'b0;
`endif
            end

            case (r_state)
                S_LOAD: begin
                    if (!w_idx_end) begin
                        if (w_cur_kind == 3'd0) begin
                            r_idx <= r_idx + 1'b1;
                        end else begin
                            r_fault_enable <= 1'b1;
                            r_fault_type   <= w_cur_kind;
                            r_fault_addr   <= r_addr[r_idx[IDX_W-1:0]];
                            r_fault_target <= r_target[r_idx[IDX_W-1:0]];
                        end
                    end
                end
                S_WAIT: begin
                    if (w_next == S_LOG) begin
                        r_smp_fail <= test_done & fail_flag;
                        r_smp_to   <= ~test_done;
                        r_smp_addr <= fail_addr;
                    end
                end
                S_LOG: begin
`ifdef MBIST_SEQ_GOLDEN_EN
                    // Golden pass result only gates the campaign; counters untouched
                    if (r_golden) begin
                        r_golden <= 1'b0;
                        if (r_smp_fail || r_smp_to) begin
                            r_golden_fail <= 1'b1;
                        end
                    end else
`endif
                    begin
                        r_idx <= r_idx + 1'b1;
                        if (r_smp_to) begin
                            r_miss_cnt                     <= r_miss_cnt + 1'b1;
                            r_timeout_cnt                  <= r_timeout_cnt + 1'b1;
                            r_miss_mask[r_idx[IDX_W-1:0]]  <= 1'b1;
                        end else if (r_smp_fail) begin
                            r_detect_cnt     <= r_detect_cnt + 1'b1;
                            r_last_fail_addr <= r_smp_addr;
                        end else begin
                            r_miss_cnt                     <= r_miss_cnt + 1'b1;
                            r_miss_mask[r_idx[IDX_W-1:0]]  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (w_next == S_FIN) begin
                r_fault_enable <= 1'b0;
                r_fault_addr   <= '0;
                r_fault_type   <= '0;
                r_fault_target <= '0;
            end
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign ctrl_rst       = r_ctrl_rst;
    assign mbist_start    = r_mbist_start;
    assign fault_enable   = r_fault_enable;
    assign fault_addr     = r_fault_addr;
    assign fault_type     = r_fault_type;
    assign fault_target   = r_fault_target;
    assign detect_cnt     = r_detect_cnt;
    assign miss_cnt       = r_miss_cnt;
    assign timeout_cnt    = r_timeout_cnt;
    assign miss_mask      = r_miss_mask;
    assign last_fail_addr = r_last_fail_addr;
`ifdef MBIST_SEQ_GOLDEN_EN
    assign golden_fail    = r_golden_fail;
`else
    assign golden_fail    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mbist_fault_campaign_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mbist_fault_campaign_seq
// Brief    : Scoreboard bench with a stub MBIST controller for the campaign
//            sequencer.
// Revision : 1.0
// ============================================================================
module tb_mbist_fault_campaign_seq;

    localparam int AW = 8;
    localparam int NE = 8;
    localparam int IW = 3;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [2:0]    cfg_kind;
    logic [AW-1:0] cfg_addr;
    logic [AW-1:0] cfg_target;
    logic [IW:0]   num_entries;
    logic          go;
    logic          busy;
    logic          done;
    logic          ctrl_rst;
    logic          mbist_start;
    logic          test_done;
    logic          fail_flag;
    logic [AW-1:0] fail_addr;
    logic          fault_enable;
    logic [AW-1:0] fault_addr;
    logic [2:0]    fault_type;
    logic [AW-1:0] fault_target;
    logic [IW:0]   detect_cnt;
    logic [IW:0]   miss_cnt;
    logic [IW:0]   timeout_cnt;
    logic [NE-1:0] miss_mask;
    logic [AW-1:0] last_fail_addr;
    logic          golden_fail;

    always #5 clk = ~clk;

    mbist_fault_campaign_seq #(
        .ADDR_WIDTH     (AW),
        .NUM_ENTRIES    (NE),
        .RST_CYCLES     (4),
        .ARM_CYCLES     (4),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_we         (cfg_we),
        .cfg_idx        (cfg_idx),
        .cfg_kind       (cfg_kind),
        .cfg_addr       (cfg_addr),
        .cfg_target     (cfg_target),
        .num_entries    (num_entries),
        .go             (go),
        .busy           (busy),
        .done           (done),
        .ctrl_rst       (ctrl_rst),
        .mbist_start    (mbist_start),
        .test_done      (test_done),
        .fail_flag      (fail_flag),
        .fail_addr      (fail_addr),
        .fault_enable   (fault_enable),
        .fault_addr     (fault_addr),
        .fault_type     (fault_type),
        .fault_target   (fault_target),
        .detect_cnt     (detect_cnt),
        .miss_cnt       (miss_cnt),
        .timeout_cnt    (timeout_cnt),
        .miss_mask      (miss_mask),
        .last_fail_addr (last_fail_addr),
        .golden_fail    (golden_fail)
    );

    typedef struct packed {
        logic          en;
        logic [2:0]    kind;
        logic [AW-1:0] addr;
        logic [AW-1:0] tgt;
    } pins_t;

    typedef struct packed {
        logic [IW:0]   det;
        logic [IW:0]   miss;
        logic [IW:0]   tout;
        logic [NE-1:0] mask;
        logic [AW-1:0] lfa;
        logic          gf;
    } res_t;

    pins_t         q_pins[$];
    res_t          q_res[$];
    logic [2:0]    m_kind [NE];
    logic [AW-1:0] m_addr [NE];
    logic [AW-1:0] m_tgt  [NE];
    logic          det_kind [8];
    logic          hang   = 1'b0;
    logic          gforce = 1'b0;
    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_starts = 0;
    int            n_done   = 0;
    int            rst_run  = 0;
    int            rst_len  = 0;
    int            arm_gap  = 0;
    int            lat      = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Pulse and ctrl_rst/arm-window observer, sampled mid-cycle
    initial begin : p_mon
        forever begin
            @(negedge clk);
            if (done) n_done++;
            if (ctrl_rst) begin
                rst_run++;
                arm_gap = 0;
            end else begin
                if (rst_run != 0) begin
                    rst_len = rst_run;
                    rst_run = 0;
                end
                arm_gap++;
            end
        end
    end

    // Stub controller: reports the victim address, detection decided per fault kind
    initial begin : p_stub
        pins_t p;
        test_done = 1'b0;
        fail_flag = 1'b0;
        fail_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mbist_start) begin
                n_starts++;
                check_eq("rst_len", 32'(rst_len), 32'(4));
                check_eq("arm_len", 32'(arm_gap), 32'(4));
                check_eq("start_expected", 32'(q_pins.size() != 0), 32'(1));
                if (q_pins.size() != 0) begin
                    p = q_pins.pop_front();
                    check_eq("fault_pins", 32'({fault_enable, fault_type, fault_addr, fault_target}), 32'(p));
                end
                if (!(hang && fault_enable)) begin
                    repeat (2) @(posedge clk);
                    #1;
                    test_done = 1'b1;
                    fail_flag = fault_enable ? det_kind[fault_type] : gforce;
                    fail_addr = fault_addr;
                    @(posedge clk);
                    #1;
                    test_done = 1'b0;
                    fail_flag = 1'b0;
                    fail_addr = '0;
                end
            end
        end
    end

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic cfg_entry(input int i, input logic [2:0] k, input logic [AW-1:0] a, input logic [AW-1:0] t);
        m_kind[i]  = k;
        m_addr[i]  = a;
        m_tgt[i]   = t;
        cfg_we     = 1'b1;
        cfg_idx    = IW'(i);
        cfg_kind   = k;
        cfg_addr   = a;
        cfg_target = t;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic push_expect(input int n);
        res_t r;
        int   nc;
        r  = '0;
        nc = (n > NE) ? NE : n;
`ifdef MBIST_SEQ_GOLDEN_EN
        q_pins.push_back('0);
        r.gf = gforce;
`endif
        if (!r.gf) begin
            for (int i = 0; i < nc; i++) begin
                if (m_kind[i] != 3'd0) begin
                    q_pins.push_back({1'b1, m_kind[i], m_addr[i], m_tgt[i]});
                    if (hang) begin
                        r.miss    = r.miss + 1'b1;
                        r.tout    = r.tout + 1'b1;
                        r.mask[i] = 1'b1;
                    end else if (det_kind[m_kind[i]]) begin
                        r.det = r.det + 1'b1;
                        r.lfa = m_addr[i];
                    end else begin
                        r.miss    = r.miss + 1'b1;
                        r.mask[i] = 1'b1;
                    end
                end
            end
        end
        q_res.push_back(r);
    endtask

    task automatic run_campaign(input int n, input int exp_starts);
        int   s0;
        int   d0;
        int   cyc;
        int   es;
        res_t r;
        es = exp_starts;
`ifdef MBIST_SEQ_GOLDEN_EN
        es = es + 1;
`endif
        push_expect(n);
        s0 = n_starts;
        d0 = n_done;
        num_entries = (IW + 1)'(n);
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        check_eq("busy_after_go", 32'(busy), 32'(1));
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        lat = cyc;
        check_eq("done_seen", 32'(done), 32'(1));
        r = q_res.pop_front();
        check_eq("detect_cnt", 32'(detect_cnt), 32'(r.det));
        check_eq("miss_cnt", 32'(miss_cnt), 32'(r.miss));
        check_eq("timeout_cnt", 32'(timeout_cnt), 32'(r.tout));
        check_eq("miss_mask", 32'(miss_mask), 32'(r.mask));
        check_eq("last_fail_addr", 32'(last_fail_addr), 32'(r.lfa));
        check_eq("golden_fail", 32'(golden_fail), 32'(r.gf));
        check_eq("start_count", 32'(n_starts - s0), 32'(es));
        @(posedge clk);
        #1;
        check_eq("busy_after_done", 32'(busy), 32'(0));
        check_eq("done_once", 32'(n_done - d0), 32'(1));
        check_eq("fault_enable_idle", 32'(fault_enable), 32'(0));
        check_eq("pins_left", 32'(q_pins.size()), 32'(0));
        q_pins.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : p_main
        int s0;
        int d0;
        int cyc;
        int es;
        reset       = 1'b1;
        cfg_we      = 1'b0;
        cfg_idx     = '0;
        cfg_kind    = '0;
        cfg_addr    = '0;
        cfg_target  = '0;
        num_entries = '0;
        go          = 1'b0;
        for (int k = 0; k < 8; k++) det_kind[k] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_done", 32'(done), 32'(0));
        check_eq("rst_ctrl_rst", 32'(ctrl_rst), 32'(0));
        check_eq("rst_mbist_start", 32'(mbist_start), 32'(0));
        check_eq("rst_fault_pins", 32'({fault_enable, fault_type, fault_addr, fault_target}), 32'(0));
        check_eq("rst_counts", 32'({detect_cnt, miss_cnt, timeout_cnt}), 32'(0));
        check_eq("rst_mask_lfa", 32'({miss_mask, last_fail_addr, golden_fail}), 32'(0));

        cfg_entry(0, 3'd1, 8'd12, 8'd0);
        cfg_entry(1, 3'd3, 8'd45, 8'd0);
        cfg_entry(2, 3'd7, 8'd100, 8'd101);
        for (int i = 3; i < NE; i++) cfg_entry(i, 3'd0, 8'(i), 8'(i));

        // Three detectable faults
        run_campaign(3, 3);

        // Controller never answers: single SA0 entry times out
        hang = 1'b1;
        run_campaign(1, 1);
        hang = 1'b0;

        // Empty campaign
        run_campaign(0, 0);
`ifndef MBIST_SEQ_GOLDEN_EN
        check_eq("empty_done_latency", 32'(lat), 32'(1));
`endif

        // Skipped middle entry, CPL undetected
        cfg_entry(1, 3'd0, 8'd45, 8'd0);
        det_kind[7] = 1'b0;
        run_campaign(3, 2);
        det_kind[7] = 1'b1;
        cfg_entry(1, 3'd3, 8'd45, 8'd0);

        // Oversized num_entries clamps to the full list
        cfg_entry(7, 3'd5, 8'd200, 8'd201);
        run_campaign(15, 4);
        cfg_entry(7, 3'd0, 8'd7, 8'd7);

        // go/cfg_we ignored mid-WAIT, then reset aborts without done
        hang = 1'b1;
        es   = 1;
`ifdef MBIST_SEQ_GOLDEN_EN
        q_pins.push_back('0);
        es = 2;
`endif
        q_pins.push_back({1'b1, m_kind[0], m_addr[0], m_tgt[0]});
        s0 = n_starts;
        d0 = n_done;
        num_entries = 4'd3;
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        cyc = 0;
        while ((n_starts - s0) < es && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("abort_reached_wait", 32'(n_starts - s0), 32'(es));
        repeat (5) @(posedge clk);
        #1;
        go         = 1'b1;
        cfg_we     = 1'b1;
        cfg_idx    = 3'd0;
        cfg_kind   = 3'd2;
        cfg_addr   = 8'hEE;
        cfg_target = 8'hEF;
        @(posedge clk);
        #1;
        go     = 1'b0;
        cfg_we = 1'b0;
        check_eq("busy_go_ignored", 32'(busy), 32'(1));
        check_eq("pins_go_ignored", 32'({fault_enable, fault_type, fault_addr}), 32'({1'b1, m_kind[0], m_addr[0]}));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("abort_fault_enable", 32'(fault_enable), 32'(0));
        check_eq("abort_busy", 32'(busy), 32'(0));
        check_eq("abort_counts", 32'({detect_cnt, miss_cnt, timeout_cnt}), 32'(0));
        repeat (10) @(posedge clk);
        #1;
        check_eq("abort_no_done", 32'(n_done - d0), 32'(0));
        hang = 1'b0;
        q_pins.delete();

        // Fault list survives reset and the ignored mid-campaign write
        run_campaign(3, 3);

`ifdef MBIST_SEQ_GOLDEN_EN
        gforce = 1'b1;
        run_campaign(3, 0);
        gforce = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
